ctrl_packet_injector: RTL and testbench

Head-of-chain stage placed directly upstream of the first processing module. It forwards the upstream packet stream one cycle late. It also turns host register commands into relative-addressed control packets (CTRL_WRITE_32b / CTRL_READ_REQUEST_32b) and inserts them into idle bus cycles. It captures the matching CP_A_CTRL_READ_RESPONSE_32b that returns around the ring on its Front input, and it owns the read timeout.

---
 rtl/ctrl_packet_injector_if.sv | 37 +++
 rtl/ctrl_packet_injector.sv | 79 +++++++
 tb/tb_ctrl_packet_injector.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_packet_injector_if.sv
// ctrl_packet_injector_if: Front_* upstream beat in, Back_* downstream beat out, Cmd_* host command handshake, Rsp_* read completion
interface ctrl_packet_injector_if #(
  parameter int DATA_WIDTH = 512,
  parameter int STREAM_ID_NUM = 16,
  parameter int CHUNK_ID_NUM = 32,
  parameter int CHANNEL_ID_NUM = 1024,
  parameter int STATE_WIDTH = 32
);
  localparam int SW = $clog2(STREAM_ID_NUM);
  localparam int CW = $clog2(CHUNK_ID_NUM);
  localparam int HW = $clog2(CHANNEL_ID_NUM);
  logic [DATA_WIDTH-1:0] Front_Data, Back_Data;
  logic [1:0] Front_Type, Back_Type;
  logic Front_Last, Back_Last;
  logic [SW-1:0] Front_StreamID, Back_StreamID;
  logic [CW-1:0] Front_ChunkID, Back_ChunkID;
  logic [HW-1:0] Front_ChannelID, Back_ChannelID;
  logic [STATE_WIDTH-1:0] Front_State, Back_State;
  logic Cmd_Valid, Cmd_Ready, Cmd_Write;
  logic [HW-1:0] Cmd_Hop;
  logic [STATE_WIDTH-1:0] Cmd_Addr;
  logic [31:0] Cmd_WData;
  logic Rsp_Valid, Rsp_Timeout;
  logic [31:0] Rsp_RData;
  modport slave (
    input Front_Data, Front_Type, Front_Last, Front_StreamID, Front_ChunkID, Front_ChannelID, Front_State,
    input Cmd_Valid, Cmd_Write, Cmd_Hop, Cmd_Addr, Cmd_WData,
    output Back_Data, Back_Type, Back_Last, Back_StreamID, Back_ChunkID, Back_ChannelID, Back_State,
    output Cmd_Ready, Rsp_Valid, Rsp_RData, Rsp_Timeout
  );
  modport master (
    output Front_Data, Front_Type, Front_Last, Front_StreamID, Front_ChunkID, Front_ChannelID, Front_State,
    output Cmd_Valid, Cmd_Write, Cmd_Hop, Cmd_Addr, Cmd_WData,
    input Back_Data, Back_Type, Back_Last, Back_StreamID, Back_ChunkID, Back_ChannelID, Back_State,
    input Cmd_Ready, Rsp_Valid, Rsp_RData, Rsp_Timeout
  );
endinterface

// File: rtl/ctrl_packet_injector.sv
// ctrl_packet_injector: forwards Front beats to Back one cycle late, injects host read/write control packets into bubbles and captures read responses (ports: clk, rstIn, bus.slave)
module ctrl_packet_injector #(
  parameter int DATA_WIDTH = 512,
  parameter int STREAM_ID_NUM = 16,
  parameter int CHUNK_ID_NUM = 32,
  parameter int CHANNEL_ID_NUM = 1024,
  parameter int STATE_WIDTH = 32,
  parameter int CP_A_CTRL_READ_RESPONSE_32b = 1,
  parameter int CP_R_CTRL_READ_REQUEST_32b = 0,
  parameter int CP_R_CTRL_WRITE_32b = 1,
  parameter int CTRL_STREAM_ID = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rstIn,
  ctrl_packet_injector_if.slave bus
);
  localparam int SW = $clog2(STREAM_ID_NUM);
  localparam int CW = $clog2(CHUNK_ID_NUM);
  localparam int HW = $clog2(CHANNEL_ID_NUM);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  state_t state, state_n;
  logic wr;
  logic [HW-1:0] hop;
  logic [STATE_WIDTH-1:0] addr;
  logic [31:0] wdata;
  logic [TW-1:0] timer;
  logic inject, match, tout, pass;
  assign bus.Cmd_Ready = state == IDLE && !rstIn;
  always_comb begin
    inject = state == ISSUE && bus.Front_Type == 2'b00;
    match = state == WAIT_RSP && bus.Front_Type == 2'b10 && !bus.Front_ChunkID[CW-1] &&
            bus.Front_ChunkID[CW-2:0] == (CW-1)'(CP_A_CTRL_READ_RESPONSE_32b) && bus.Front_State == addr;
    tout = state == WAIT_RSP && timer == TW'(TIMEOUT_CYCLES - 1);
    pass = !inject && !match;
    state_n = (state == IDLE && bus.Cmd_Valid) ? ISSUE :
              inject ? (wr ? IDLE : WAIT_RSP) :
              (match || tout) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rstIn) begin
      state <= IDLE;
      timer <= '0;
      bus.Back_Data <= '0;
      bus.Back_Type <= '0;
      bus.Back_Last <= 1'b0;
      bus.Back_StreamID <= '0;
      bus.Back_ChunkID <= '0;
      bus.Back_ChannelID <= '0;
      bus.Back_State <= '0;
      bus.Rsp_Valid <= 1'b0;
      bus.Rsp_RData <= '0;
      bus.Rsp_Timeout <= 1'b0;
    end else begin
      state <= state_n;
      timer <= state == WAIT_RSP ? timer + TW'(1) : '0;
      bus.Back_Data <= inject ? (wr ? {(DATA_WIDTH/32){wdata}} : '0) : pass ? bus.Front_Data : '0;
      bus.Back_Type <= inject ? 2'b10 : pass ? bus.Front_Type : 2'b00;
      bus.Back_Last <= inject ? 1'b1 : pass && bus.Front_Last;
      bus.Back_StreamID <= inject ? SW'(CTRL_STREAM_ID) : pass ? bus.Front_StreamID : '0;
      bus.Back_ChunkID <= inject ? {1'b1, (CW-1)'(wr ? CP_R_CTRL_WRITE_32b : CP_R_CTRL_READ_REQUEST_32b)} :
                          pass ? bus.Front_ChunkID : '0;
      bus.Back_ChannelID <= inject ? hop : pass ? bus.Front_ChannelID : '0;
      bus.Back_State <= inject ? addr : pass ? bus.Front_State : '0;
      bus.Rsp_Valid <= match || tout;
      bus.Rsp_RData <= match ? bus.Front_Data[31:0] : '0;
      bus.Rsp_Timeout <= tout && !match;
    end
  end
  always_ff @(posedge clk) begin
    if (bus.Cmd_Ready && bus.Cmd_Valid) begin
      wr <= bus.Cmd_Write;
      hop <= bus.Cmd_Hop;
      addr <= bus.Cmd_Addr;
      wdata <= bus.Cmd_WData;
    end
  end
endmodule

// File: tb/tb_ctrl_packet_injector.sv
// tb_ctrl_packet_injector: scoreboard bench driving per-cycle stimulus and comparing Back/Rsp/Cmd_Ready against queued expectations
module tb_ctrl_packet_injector;
  localparam int DW = 512, SW = 4, CW = 5, HW = 10, STW = 32, TO = 8;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0] typ;
    logic last;
    logic [SW-1:0] sid;
    logic [CW-1:0] cid;
    logic [HW-1:0] chid;
    logic [STW-1:0] st;
  } beat_t;
  typedef struct packed {
    beat_t back;
    logic rv;
    logic [31:0] rd;
    logic rt;
    logic rdy;
  } obs_t;
  typedef struct packed {
    logic rst;
    logic cv;
    logic cw;
    logic [HW-1:0] hop;
    logic [STW-1:0] addr;
    logic [31:0] wd;
    beat_t f;
  } stim_t;
  logic clk = 1'b0;
  logic rstIn;
  ctrl_packet_injector_if b();
  ctrl_packet_injector #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rstIn(rstIn), .bus(b));
  always #5 clk = ~clk;
  stim_t sq[$];
  obs_t eq[$];
  int checks = 0, errors = 0;

  function automatic beat_t bt(logic [1:0] t, logic l, logic [SW-1:0] s, logic [CW-1:0] c,
                               logic [HW-1:0] h, logic [STW-1:0] st, logic [DW-1:0] d);
    bt = '{data: d, typ: t, last: l, sid: s, cid: c, chid: h, st: st};
  endfunction
  function automatic logic [DW-1:0] rnd();
    for (int i = 0; i < DW / 32; i++) rnd[i*32 +: 32] = $urandom;
  endfunction
  function automatic beat_t wr_pkt(logic [HW-1:0] h, logic [STW-1:0] a, logic [31:0] w);
    wr_pkt = bt(2'b10, 1'b1, '0, 5'h11, h, a, {16{w}});
  endfunction
  function automatic beat_t rd_pkt(logic [HW-1:0] h, logic [STW-1:0] a);
    rd_pkt = bt(2'b10, 1'b1, '0, 5'h10, h, a, '0);
  endfunction
  function automatic beat_t rsp_beat(logic [STW-1:0] a, logic [31:0] v);
    logic [DW-1:0] d;
    d = rnd();
    d[31:0] = v;
    rsp_beat = bt(2'b10, 1'b1, '0, 5'h01, '0, a, d);
  endfunction
  function automatic stim_t cyc(beat_t f);
    cyc = '0;
    cyc.f = f;
  endfunction
  function automatic stim_t cmd(logic w, logic [HW-1:0] h, logic [STW-1:0] a, logic [31:0] wd, beat_t f);
    cmd = '{rst: 1'b0, cv: 1'b1, cw: w, hop: h, addr: a, wd: wd, f: f};
  endfunction
  function automatic obs_t ob(beat_t bk, logic rv, logic [31:0] rd, logic rt, logic rdy);
    ob = '{back: bk, rv: rv, rd: rd, rt: rt, rdy: rdy};
  endfunction
  function automatic obs_t sample();
    sample.back = bt(b.Back_Type, b.Back_Last, b.Back_StreamID, b.Back_ChunkID, b.Back_ChannelID,
                     b.Back_State, b.Back_Data);
    sample.rv = b.Rsp_Valid;
    sample.rd = b.Rsp_RData;
    sample.rt = b.Rsp_Timeout;
    sample.rdy = b.Cmd_Ready;
  endfunction
  task automatic drive(stim_t s);
    rstIn = s.rst;
    b.Cmd_Valid = s.cv;
    b.Cmd_Write = s.cw;
    b.Cmd_Hop = s.hop;
    b.Cmd_Addr = s.addr;
    b.Cmd_WData = s.wd;
    b.Front_Data = s.f.data;
    b.Front_Type = s.f.typ;
    b.Front_Last = s.f.last;
    b.Front_StreamID = s.f.sid;
    b.Front_ChunkID = s.f.cid;
    b.Front_ChannelID = s.f.chid;
    b.Front_State = s.f.st;
  endtask
  task automatic push(stim_t s, obs_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s;
    obs_t g, e;
    s = cyc(bt(2'b01, 1'b1, 4'h3, 5'h07, 10'h15, 32'h55, rnd()));
    s.rst = 1'b1;
    push(s, ob('0, 0, 0, 0, 0));
    push(s, ob('0, 0, 0, 0, 0));
    push(cyc('0), ob('0, 0, 0, 0, 1));
    for (int k = 0; sq.size() > 0; k++) begin
      drive(sq.pop_front());
      @(posedge clk);
      #1;
      g = sample();
      e = eq.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset cyc %0d got %h exp %h", k, g, e);
      end
    end
  endtask

  task automatic test_write();
    beat_t d;
    obs_t g, e;
    d = bt(2'b01, 1'b0, 4'h9, 5'h0a, 10'h2f, 32'h1234_5678, rnd());
    push(cyc(d), ob(d, 0, 0, 0, 1));
    push(cmd(1'b1, 10'd3, 32'h10, 32'hCAFEF00D, '0), ob('0, 0, 0, 0, 0));
    push(cyc('0), ob(wr_pkt(10'd3, 32'h10, 32'hCAFEF00D), 0, 0, 0, 1));
    push(cyc('0), ob('0, 0, 0, 0, 1));
    for (int k = 0; sq.size() > 0; k++) begin
      drive(sq.pop_front());
      @(posedge clk);
      #1;
      g = sample();
      e = eq.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL write cyc %0d got %h exp %h", k, g, e);
      end
    end
  endtask

  task automatic test_read_busy();
    beat_t d, r;
    obs_t g, e;
    for (int i = 0; i < 5; i++) begin
      d = bt(2'b01, i == 4, SW'(i + 2), CW'(i), HW'(i * 7), STW'(i * 3), rnd());
      push(i == 0 ? cmd(1'b0, 10'd0, 32'h20, 32'h0, d) : cyc(d), ob(d, 0, 0, 0, 0));
    end
    push(cyc('0), ob(rd_pkt(10'd0, 32'h20), 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) push(cyc('0), ob('0, 0, 0, 0, 0));
    r = rsp_beat(32'h20, 32'h1234);
    push(cyc(r), ob('0, 1, 32'h1234, 0, 1));
    push(cyc('0), ob('0, 0, 0, 0, 1));
    for (int k = 0; sq.size() > 0; k++) begin
      drive(sq.pop_front());
      @(posedge clk);
      #1;
      g = sample();
      e = eq.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL read_busy cyc %0d got %h exp %h", k, g, e);
      end
    end
  endtask

  task automatic test_timeout();
    beat_t r;
    obs_t g, e;
    push(cmd(1'b0, 10'd5, 32'h20, 32'h0, '0), ob('0, 0, 0, 0, 0));
    push(cyc('0), ob(rd_pkt(10'd5, 32'h20), 0, 0, 0, 0));
    for (int i = 0; i < TO - 1; i++) push(cyc('0), ob('0, 0, 0, 0, 0));
    push(cyc('0), ob('0, 1, 32'h0, 1, 1));
    r = rsp_beat(32'h20, 32'h9999_0001);
    push(cyc(r), ob(r, 0, 0, 0, 1));
    push(cyc('0), ob('0, 0, 0, 0, 1));
    for (int k = 0; sq.size() > 0; k++) begin
      drive(sq.pop_front());
      @(posedge clk);
      #1;
      g = sample();
      e = eq.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL timeout cyc %0d got %h exp %h", k, g, e);
      end
    end
  endtask

  task automatic test_mismatch_last();
    beat_t r24, rel, r20;
    obs_t g, e;
    r24 = rsp_beat(32'h24, 32'h0000_0024);
    rel = bt(2'b10, 1'b1, 4'h0, 5'h11, 10'd1, 32'h20, rnd());
    r20 = rsp_beat(32'h20, 32'hABCD_5678);
    push(cmd(1'b0, 10'd2, 32'h20, 32'h0, '0), ob('0, 0, 0, 0, 0));
    push(cyc('0), ob(rd_pkt(10'd2, 32'h20), 0, 0, 0, 0));
    push(cyc(r24), ob(r24, 0, 0, 0, 0));
    push(cyc(rel), ob(rel, 0, 0, 0, 0));
    for (int i = 0; i < TO - 3; i++) push(cyc('0), ob('0, 0, 0, 0, 0));
    push(cyc(r20), ob('0, 1, 32'hABCD_5678, 0, 1));
    push(cyc('0), ob('0, 0, 0, 0, 1));
    for (int k = 0; sq.size() > 0; k++) begin
      drive(sq.pop_front());
      @(posedge clk);
      #1;
      g = sample();
      e = eq.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL mismatch_last cyc %0d got %h exp %h", k, g, e);
      end
    end
  endtask

  task automatic test_reset_wait();
    stim_t s;
    obs_t g, e;
    push(cmd(1'b0, 10'd1, 32'h20, 32'h0, '0), ob('0, 0, 0, 0, 0));
    push(cyc('0), ob(rd_pkt(10'd1, 32'h20), 0, 0, 0, 0));
    push(cyc('0), ob('0, 0, 0, 0, 0));
    s = cyc(bt(2'b01, 1'b1, 4'h5, 5'h03, 10'd9, 32'h77, rnd()));
    s.rst = 1'b1;
    push(s, ob('0, 0, 0, 0, 0));
    for (int i = 0; i < TO + 3; i++) push(cyc('0), ob('0, 0, 0, 0, 1));
    push(cmd(1'b1, 10'd7, 32'h44, 32'h0BADBEEF, '0), ob('0, 0, 0, 0, 0));
    push(cyc('0), ob(wr_pkt(10'd7, 32'h44, 32'h0BADBEEF), 0, 0, 0, 1));
    push(cyc('0), ob('0, 0, 0, 0, 1));
    for (int k = 0; sq.size() > 0; k++) begin
      drive(sq.pop_front());
      @(posedge clk);
      #1;
      g = sample();
      e = eq.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_wait cyc %0d got %h exp %h", k, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    beat_t r;
    obs_t g, e;
    r = rsp_beat(32'h30, 32'h0F0F_1E1E);
    push(cmd(1'b1, 10'd12, 32'h08, 32'h8000_0001, '0), ob('0, 0, 0, 0, 0));
    push(cyc('0), ob(wr_pkt(10'd12, 32'h08, 32'h8000_0001), 0, 0, 0, 1));
    push(cmd(1'b0, 10'd4, 32'h30, 32'h0, '0), ob('0, 0, 0, 0, 0));
    push(cyc('0), ob(rd_pkt(10'd4, 32'h30), 0, 0, 0, 0));
    push(cyc(r), ob('0, 1, 32'h0F0F_1E1E, 0, 1));
    push(cyc('0), ob('0, 0, 0, 0, 1));
    for (int k = 0; sq.size() > 0; k++) begin
      drive(sq.pop_front());
      @(posedge clk);
      #1;
      g = sample();
      e = eq.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %h exp %h", k, g, e);
      end
    end
  endtask

  initial begin
    drive('0);
    test_reset();
    test_write();
    test_read_busy();
    test_timeout();
    test_mismatch_last();
    test_reset_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
